writeback_buffer: RTL
=====================

Name: writeback_buffer

Overview:
- Line-granular write-back buffer between the L1 data cache's line-adapter eviction path and the delayed single-port main memory.
- Accepts a dirty victim line as an 8-word burst in 8 consecutive accepted beats, frees the cache controller immediately, and drains the line to main memory in the background.
- Provides a tag-lookup port so the cache controller stalls a refill of any line still held in the buffer.

Parameters:
- WORD_SIZE, 32, bits per word
- WORDS_PER_LINE, 8, words per cache line; power of two
- DEPTH, 2, line entries held; 1..4
- ADDR_SIZE, 32, byte-address width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in_valid  in  1  fill beat present
- in_ready  out  1  fill beat accepted when in_valid & in_ready
- in_addr  in  ADDR_SIZE  byte address of victim line; sampled on beat 0 only
- in_data  in  WORD_SIZE  fill word; beat k carries word k
- mm_we  out  1  write request to main memory, held for the whole burst
- mm_addr  out  ADDR_SIZE  word address {2'b0, line_base[31:2]}, constant during burst
- mm_data  out  WORD_SIZE  word currently offered to main memory
- mm_valid  in  1  main memory consumed mm_data this cycle
- lk_addr  in  ADDR_SIZE  byte address looked up by the cache controller
- lk_hit  out  1  combinational; lk_addr's line is held in any occupied entry
- empty  out  1  no entries occupied
- full  out  1  all DEPTH entries occupied

Behaviour:
- Line base = addr[ADDR_SIZE-1:5] with low 5 bits zero (for WORDS_PER_LINE=8).
- Each entry holds: state (FREE, FILLING, READY, DRAINING), base, and WORDS_PER_LINE words.
- Entries are allocated and drained in FIFO order using write and read pointers modulo DEPTH.
- Fill side:
  - Beat 0 allocates the entry at the write pointer and latches the base; the entry becomes FILLING.
  - The fill word counter increments on each accepted beat.
  - The beat with counter = WORDS_PER_LINE-1 marks the entry READY, advances the write pointer and clears the counter.
  - in_ready = mid-fill (counter != 0) OR an entry is FREE at the write pointer. A line in progress therefore always completes.
  - in_addr on beats 1..7 is ignored.
- Drain FSM:
  - IDLE: if the entry at the read pointer is READY, go to DRAIN the next cycle. mm_we = 0.
  - DRAIN: mm_we = 1, mm_addr = entry base word address, mm_data = word[drain_idx]. On mm_valid, drain_idx increments.
  - On mm_valid with drain_idx = WORDS_PER_LINE-1: the entry becomes FREE, the read pointer advances, drain_idx clears, and the FSM goes to GAP.
  - GAP: mm_we = 0 for exactly one cycle, then IDLE. This guarantees the memory sees a fresh request edge per line.
- Latency:
  - A line completing fill at cycle t raises mm_we at t+2 if the buffer was idle.
  - Drain time is bounded only by mm_valid.
- Simultaneous events:
  - Final fill beat and final drain beat in the same cycle: both take effect.
  - A FREE entry produced this cycle is not visible to in_ready until the next cycle.
- lk_hit:
  - Compares lk_addr's line base against every entry in FILLING, READY or DRAINING.
  - It drops in the cycle after the final mm_valid of the matching line.
  - Duplicate bases are legal; the FIFO order keeps the newest copy last to memory.
- full / empty: registered views of entry occupancy. empty = 1 with all entries FREE; full = 1 with none FREE.
- Reset (any cycle, including mid-fill or mid-burst):
  - All entries go FREE; pointers, counters and drain_idx clear; FSM goes to IDLE.
  - mm_we = 0, mm_addr = 0, mm_data = 0, in_ready = 1, empty = 1, full = 0 in the cycle after reset is sampled.
  - A partially drained line is discarded.
- mm_valid outside DRAIN is ignored. in_valid with in_ready = 0 has no effect.

Optional Feature:
- Macro: WB_FORWARD_EN
- Defined: adds output lk_data [WORD_SIZE-1:0], combinational.
  - Returns word lk_addr[4:2] from the newest matching entry that is READY or DRAINING.
  - A FILLING entry whose counter already passed that word also counts as a source.
  - Adds output lk_fwd, which is 1 when lk_data is valid.
  - The controller may then satisfy a read hit on a pending victim without stalling.
- Not defined: neither port exists, and lk_hit alone gates refills.

Test Plan:
- Single line: fill base 0x0000_6020 with words 0x11..0x18, mm_valid held high → mm_we rises 2 cycles after the last beat; mm_addr = 0x0000_1808; mm_data sequence 0x11..0x18; empty = 1 after GAP.
- Back-pressure: DEPTH = 2, mm_valid = 0, fill lines at 0x6000 and 0x6100, then offer a third → full = 1 and in_ready = 0. Pulse mm_valid 8 times → first line freed, in_ready = 1, third line accepted.
- Lookup: line 0x6040 pending → lk_addr = 0x6058 gives lk_hit = 1 and lk_addr = 0x6060 gives lk_hit = 0. lk_hit = 0 the cycle after the 8th mm_valid.
- Simultaneous: final fill beat of line B coincides with the final mm_valid of line A → both complete, GAP lasts one cycle, and mm_we for B follows in the next IDLE→DRAIN transition.
- Reset mid-burst: assert reset after the 3rd mm_valid → mm_we = 0 the next cycle, empty = 1, lk_hit = 0 for the previous line address.
- WB_FORWARD_EN: line 0x6080 words 0xA0..0xA7 pending, lk_addr = 0x6094 → lk_fwd = 1, lk_data = 0xA5.

Source files
------------

// File: rtl/writeback_buffer_if.sv
// Fill-side and main-memory-side handshake bundle for the write-back buffer.
// master = cache/memory environment, slave = writeback_buffer.
interface writeback_buffer_if #(
    parameter int ADDR_SIZE = 32,
    parameter int WORD_SIZE = 32
);
    logic                 in_valid;
    logic                 in_ready;
    logic [ADDR_SIZE-1:0] in_addr;
    logic [WORD_SIZE-1:0] in_data;
    logic                 mm_we;
    logic [ADDR_SIZE-1:0] mm_addr;
    logic [WORD_SIZE-1:0] mm_data;
    logic                 mm_valid;

    modport master (
        output in_valid, in_addr, in_data, mm_valid,
        input  in_ready, mm_we, mm_addr, mm_data
    );

    modport slave (
        input  in_valid, in_addr, in_data, mm_valid,
        output in_ready, mm_we, mm_addr, mm_data
    );
endinterface

// File: rtl/writeback_buffer.sv
// Line-granular write-back buffer: FIFO of victim lines drained to main memory.
// Define WB_FORWARD_EN to add the lk_data/lk_fwd read-forwarding outputs.
module writeback_buffer #(
    parameter int WORD_SIZE      = 32,
    parameter int WORDS_PER_LINE = 8,
    parameter int DEPTH          = 2,
    parameter int ADDR_SIZE      = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    writeback_buffer_if.slave    bus,
    input  logic [ADDR_SIZE-1:0] lk_addr,
    output logic                 lk_hit,
    output logic                 empty,
    output logic                 full
`ifdef WB_FORWARD_EN
    ,
    output logic [WORD_SIZE-1:0] lk_data,
    output logic                 lk_fwd
`endif
);
    localparam int OFS = $clog2(WORDS_PER_LINE * (WORD_SIZE / 8));
    localparam int BW  = ADDR_SIZE - OFS;
    localparam int CW  = $clog2(WORDS_PER_LINE);
    localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {E_FREE, E_FILLING, E_READY, E_DRAINING} ent_t;
    typedef enum logic [1:0] {D_IDLE, D_DRAIN, D_GAP} dst_t;

    ent_t [DEPTH-1:0]                                st, st_nxt;
    logic [DEPTH-1:0][BW-1:0]                        base_q;
    logic [DEPTH-1:0][WORDS_PER_LINE-1:0][WORD_SIZE-1:0] line_q;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] cnt, drain_idx;
    dst_t          dstate, dnxt;
    logic          fire, drain_last, all_free, none_free;
    logic          mm_we, in_ready;
    logic [ADDR_SIZE-1:0] mm_addr;
    logic [WORD_SIZE-1:0] mm_data;
    logic [BW-1:0] lk_base;
    logic          unused_ok;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // A started line always completes, so mid-fill ignores entry state.
    assign in_ready     = (cnt != '0) || (st[wr_ptr] == E_FREE);
    assign fire         = bus.in_valid && in_ready;
    assign lk_base      = lk_addr[ADDR_SIZE-1:OFS];
    assign bus.in_ready = in_ready;
    assign bus.mm_we    = mm_we;
    assign bus.mm_addr  = mm_addr;
    assign bus.mm_data  = mm_data;
    assign unused_ok    = ^{bus.in_addr[OFS-1:0], lk_addr[OFS-1:0]};

    // Fill and drain never touch the same entry in one cycle: the fill entry
    // is FREE/FILLING while the drain entry is READY/DRAINING.
    always_comb begin
        st_nxt = st;
        if (fire)
            st_nxt[wr_ptr] = (cnt == LAST) ? E_READY : E_FILLING;
        if (dstate == D_IDLE && st[rd_ptr] == E_READY)
            st_nxt[rd_ptr] = E_DRAINING;
        if (drain_last)
            st_nxt[rd_ptr] = E_FREE;
    end

    always_comb begin
        all_free  = 1'b1;
        none_free = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            if (st_nxt[i] == E_FREE) none_free = 1'b0;
            else                     all_free  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st     <= '{default: E_FREE};
            wr_ptr <= '0;
            cnt    <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            st    <= st_nxt;
            empty <= all_free;
            full  <= none_free;
            if (fire) begin
                if (cnt == LAST) begin
                    cnt    <= '0;
                    wr_ptr <= inc(wr_ptr);
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fire) begin
            line_q[wr_ptr][cnt] <= bus.in_data;
            if (cnt == '0) base_q[wr_ptr] <= bus.in_addr[ADDR_SIZE-1:OFS];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dstate    <= D_IDLE;
            rd_ptr    <= '0;
            drain_idx <= '0;
        end else begin
            dstate <= dnxt;
            if (dstate == D_DRAIN && bus.mm_valid)
                drain_idx <= (drain_idx == LAST) ? '0 : drain_idx + CW'(1);
            if (drain_last) rd_ptr <= inc(rd_ptr);
        end
    end

    // GAP forces one low cycle of mm_we so every line is a fresh request.
    always_comb begin
        dnxt       = dstate;
        mm_we      = 1'b0;
        mm_addr    = '0;
        mm_data    = '0;
        drain_last = 1'b0;
        case (dstate)
            D_IDLE:  if (st[rd_ptr] == E_READY) dnxt = D_DRAIN;
            D_DRAIN: begin
                mm_we   = 1'b1;
                mm_addr = {2'b00, base_q[rd_ptr], {(OFS-2){1'b0}}};
                mm_data = line_q[rd_ptr][drain_idx];
                if (bus.mm_valid && drain_idx == LAST) begin
                    drain_last = 1'b1;
                    dnxt       = D_GAP;
                end
            end
            D_GAP:   dnxt = D_IDLE;
            default: dnxt = D_IDLE;
        endcase
    end

    always_comb begin
        lk_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            if (st[i] != E_FREE && base_q[i] == lk_base) lk_hit = 1'b1;
    end

`ifdef WB_FORWARD_EN
    logic [CW-1:0] lk_word;
    logic [PW-1:0] fwd_idx;
    assign lk_word = lk_addr[OFS-1:OFS-CW];

    // Walk oldest to newest from rd_ptr so the newest match wins.
    always_comb begin
        lk_fwd  = 1'b0;
        lk_data = '0;
        fwd_idx = rd_ptr;
        for (int k = 0; k < DEPTH; k++) begin
            fwd_idx = PW'((int'(rd_ptr) + k) % DEPTH);
            if (base_q[fwd_idx] == lk_base &&
                (st[fwd_idx] == E_READY || st[fwd_idx] == E_DRAINING ||
                 (st[fwd_idx] == E_FILLING && cnt > lk_word))) begin
                lk_fwd  = 1'b1;
                lk_data = line_q[fwd_idx][lk_word];
            end
        end
    end
`endif
endmodule
